// File: rtl/sp_load_deser_if.sv
// ----------------------------------------------------------------------------
// sp_load_deser_if
//   Bundles the serial-in handshake and the parallel load outputs of
//   sp_load_deser. The interface carries no logic of its own.
//
//   Handshake: a bit on DI is transferred at a rising CK edge exactly when
//   DV and DRDY are both 1 at that edge. DV may rise or fall freely, and
//   DI is only meaningful while DV is 1. DRDY never depends on DV.
//
//   Signals
//     DI     master -> slave  serial data bit
//     DV     master -> slave  DI valid
//     ABORT  master -> slave  discard the partial word
//     DRDY   slave  -> master stage can accept a bit this cycle
//     Q      slave  -> master assembled WIDTH-bit word (to the bank D pins)
//     SP     slave  -> master one-cycle load strobe (to the bank SP pins)
//     PERR   slave  -> master one-cycle parity error pulse
// ----------------------------------------------------------------------------
interface sp_load_deser_if #(
  parameter int WIDTH = 8
);
  logic             DI;
  logic             DV;
  logic             ABORT;
  logic             DRDY;
  logic [WIDTH-1:0] Q;
  logic             SP;
  logic             PERR;

  modport master (
    output DI, DV, ABORT,
    input  DRDY, Q, SP, PERR
  );

  modport slave (
    input  DI, DV, ABORT,
    output DRDY, Q, SP, PERR
  );
endinterface

// File: rtl/sp_load_deser.sv
// ----------------------------------------------------------------------------
// sp_load_deser
//   Serial-to-parallel load stage that feeds a bank of FD1P3JX enable flops.
//   It collects WIDTH serial bits into a word and then, for one cycle, drives
//   SP high while Q holds the new word. Q only changes on entry to LOAD, so
//   the word is stable for the whole strobe cycle and stays stable afterwards.
//
//   Optional feature: define PARITY_CHK_EN to add a PAR state. In that state
//   the stage takes one extra even-parity bit after the data bits. A good
//   parity bit loads the word. A bad one drops the word and pulses PERR.
//   If the macro is undefined, PERR is tied to 0.
//
//   Parameters
//     WIDTH      word length, 1..32
//     MSB_FIRST  1: first serial bit ends in Q[WIDTH-1]; 0: ends in Q[0]
//
//   Ports
//     CK           rising-edge clock
//     CD           synchronous active-high reset (highest priority)
//     bus          sp_load_deser_if.slave (DI, DV, ABORT, DRDY, Q, SP, PERR)
//     dbg_state_o  current FSM state (IDLE=0, SHIFT=1, PAR=2, LOAD=3)
// ----------------------------------------------------------------------------
module sp_load_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  CK,
  input  logic                  CD,
  sp_load_deser_if.slave        bus,
  output logic [1:0]            dbg_state_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_PAR   = 2'd2,
    S_LOAD  = 2'd3
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_d;
  logic [WIDTH-1:0] q_q;
  logic             sp_q;
  logic             last_bit;

  // The shift register with the incoming bit already inserted. Single-bit
  // writes keep this legal for WIDTH == 1.
  always_comb begin
    sh_d = '0;
    if (MSB_FIRST) begin
      sh_d    = sh_q << 1;
      sh_d[0] = bus.DI;
    end else begin
      sh_d          = sh_q >> 1;
      sh_d[WIDTH-1] = bus.DI;
    end
  end

  // The accept on this edge completes the word.
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

`ifdef PARITY_CHK_EN
  logic perr_q;
  logic par_ok;
  // Even parity: XOR of the data bits and the parity bit must be 0.
  assign par_ok = ~((^sh_q) ^ bus.DI);
`endif

  always_ff @(posedge CK) begin
    if (CD) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      q_q     <= '0;
      sp_q    <= 1'b0;
`ifdef PARITY_CHK_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      sp_q   <= 1'b0;
`ifdef PARITY_CHK_EN
      perr_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE, S_SHIFT: begin
          if (bus.ABORT) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
          end else if (bus.DV) begin
            sh_q  <= sh_d;
            cnt_q <= cnt_q + CW'(1);
            if (last_bit) begin
`ifdef PARITY_CHK_EN
              state_q <= S_PAR;
`else
              // Q is loaded on the same edge that enters LOAD.
              q_q     <= sh_d;
              sp_q    <= 1'b1;
              state_q <= S_LOAD;
`endif
            end else begin
              state_q <= S_SHIFT;
            end
          end
        end
`ifdef PARITY_CHK_EN
        S_PAR: begin
          if (bus.ABORT) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
          end else if (bus.DV) begin
            cnt_q <= '0;
            sh_q  <= '0;
            if (par_ok) begin
              q_q     <= sh_q;
              sp_q    <= 1'b1;
              state_q <= S_LOAD;
            end else begin
              // Drop the word. Q keeps the last good word.
              perr_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end
        end
`endif
        S_LOAD: begin
          // ABORT is ignored here. The strobe has already been issued.
          state_q <= S_IDLE;
          cnt_q   <= '0;
          sh_q    <= '0;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          sh_q    <= '0;
        end
      endcase
    end
  end

  // DRDY is gated by CD so that it reads 0 for the whole time reset is held.
  assign bus.DRDY    = ~CD & (state_q != S_LOAD);
  assign bus.Q       = q_q;
  assign bus.SP      = sp_q;
`ifdef PARITY_CHK_EN
  assign bus.PERR    = perr_q;
`else
  assign bus.PERR    = 1'b0;
`endif
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sp_load_deser.sv
// ----------------------------------------------------------------------------
// tb_sp_load_deser
//   Two stages share one stimulus stream: one is MSB-first and the other is
//   LSB-first. Both are compared every cycle against a word-level model.
//   Directed sequences pin reset, latency, stalls, abort, bit order and
//   back-to-back period. A randomized phase follows them.
// ----------------------------------------------------------------------------
module tb_sp_load_deser;
  localparam int W = 8;
`ifdef PARITY_CHK_EN
  localparam int PERIOD = W + 2;
`else
  localparam int PERIOD = W + 1;
`endif

  // ---------------- clock / reset ----------------
  logic CK = 1'b0;
  logic CD = 1'b1;
  always #5 CK = ~CK;

  int cyc = 0;
  always @(posedge CK) cyc <= cyc + 1;

  logic tb_di = 1'b0;
  logic tb_dv = 1'b1;
  logic tb_abort = 1'b0;

  sp_load_deser_if #(.WIDTH(W)) bus_m ();
  sp_load_deser_if #(.WIDTH(W)) bus_l ();
  logic [1:0] dbg_m, dbg_l;

  assign bus_m.DI = tb_di;  assign bus_m.DV = tb_dv;  assign bus_m.ABORT = tb_abort;
  assign bus_l.DI = tb_di;  assign bus_l.DV = tb_dv;  assign bus_l.ABORT = tb_abort;

  sp_load_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .CK(CK), .CD(CD), .bus(bus_m), .dbg_state_o(dbg_m)
  );
  sp_load_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .CK(CK), .CD(CD), .bus(bus_l), .dbg_state_o(dbg_l)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model keeps the accepted bits as a list. It builds the word from
  // that list only when the word completes.
  logic m_bits[$];
  bit   m_load = 0, m_par = 0, m_sp = 0, m_perr = 0;
  logic [W-1:0] m_q_m = '0, m_q_l = '0;

  function automatic logic [W-1:0] pack(input bit msb);
    logic [W-1:0] w = '0;
    for (int i = 0; i < m_bits.size(); i++)
      if (msb) w[W-1-i] = m_bits[i];
      else     w[i]     = m_bits[i];
    return w;
  endfunction

  function automatic logic xor_bits();
    logic x = 1'b0;
    for (int i = 0; i < m_bits.size(); i++) x ^= m_bits[i];
    return x;
  endfunction

  always @(posedge CK) begin
    if (CD) begin
      m_bits.delete();
      m_load = 0; m_par = 0; m_sp = 0; m_perr = 0;
      m_q_m = '0; m_q_l = '0;
    end else begin
      m_sp = 0; m_perr = 0;
      if (m_load) begin
        m_load = 0;
      end else if (tb_abort) begin
        m_bits.delete();
        m_par = 0;
      end else if (tb_dv) begin
        if (m_par) begin
          if ((xor_bits() ^ tb_di) == 1'b0) begin
            m_q_m = pack(1'b1); m_q_l = pack(1'b0);
            m_sp = 1; m_load = 1;
          end else begin
            m_perr = 1;
          end
          m_bits.delete();
          m_par = 0;
        end else begin
          m_bits.push_back(tb_di);
          if (m_bits.size() == W) begin
`ifdef PARITY_CHK_EN
            m_par = 1;
`else
            m_q_m = pack(1'b1); m_q_l = pack(1'b0);
            m_sp = 1; m_load = 1;
            m_bits.delete();
`endif
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  bit chk_en = 0;
  int sp_cnt = 0;
  int perr_cnt = 0;
  int sp_cyc = -1;
  int sp_log[$];

  always @(negedge CK) begin
    if (chk_en) begin
      check("q_msb",   32'(bus_m.Q),    32'(m_q_m));
      check("q_lsb",   32'(bus_l.Q),    32'(m_q_l));
      check("sp_msb",  32'(bus_m.SP),   32'(m_sp));
      check("sp_lsb",  32'(bus_l.SP),   32'(m_sp));
      check("drdy_msb", 32'(bus_m.DRDY), 32'(!CD && !m_load));
      check("drdy_lsb", 32'(bus_l.DRDY), 32'(!CD && !m_load));
      check("perr_msb", 32'(bus_m.PERR), 32'(m_perr));
      check("perr_lsb", 32'(bus_l.PERR), 32'(m_perr));
      if (bus_m.SP === 1'b1) begin
        sp_cnt++;
        sp_cyc = cyc;
        sp_log.push_back(cyc);
      end
      if (bus_m.PERR === 1'b1) perr_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CK); #1;
      tb_dv = 1'b0; tb_abort = 1'b0;
    end
  endtask

  // Offers one bit. It waits while DRDY is low, and gives up after a
  // bounded number of cycles.
  task automatic drive_bit(input logic b, output int acc);
    bit done = 0;
    acc = -1;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge CK); #1;
      tb_di = b; tb_abort = 1'b0;
      if (bus_m.DRDY === 1'b1) begin
        tb_dv = 1'b1;
        @(posedge CK); #1;
        acc = cyc;
        done = 1;
      end else begin
        tb_dv = 1'b0;
      end
    end
    if (!done) check("accept_timeout", 32'(0), 32'(1));
  endtask

  // Sends w MSB-first on the wire. It stalls for `gap` cycles before wire
  // bit index gap_at. Under parity, the correct even-parity bit follows.
  task automatic send_word(input logic [W-1:0] w, input int gap_at, input int gap,
                           output int first, output int last);
    int a;
    first = -1;
    for (int k = 0; k < W; k++) begin
      if (k == gap_at && gap > 0) idle(gap);
      drive_bit(w[W-1-k], a);
      if (k == 0) first = a;
    end
`ifdef PARITY_CHK_EN
    drive_bit(^w, a);
`endif
    last = a;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int f2, l2, f3, l3, f, l, d2, sp0, a;

    // 1: reset held for 3 cycles with DV=1
    @(posedge CK);
    chk_en = 1;
    repeat (3) begin
      @(negedge CK);
      check("rst_q",    32'(bus_m.Q),    32'h0);
      check("rst_sp",   32'(bus_m.SP),   32'h0);
      check("rst_drdy", 32'(bus_m.DRDY), 32'h0);
      @(posedge CK);
    end
    @(negedge CK); #1;
    CD = 1'b0; tb_dv = 1'b0;
    @(negedge CK);
    check("drdy_after_rst", 32'(bus_m.DRDY), 32'h1);

    // 2: A5 sent with DV high the whole time
    sp0 = sp_cnt;
    send_word(8'hA5, -1, 0, f2, l2);
    idle(3);
    check("t2_sp_count", 32'(sp_cnt - sp0), 32'd1);
    check("t2_sp_latency", 32'(sp_cyc), 32'(l2));
    check("t2_q", 32'(bus_m.Q), 32'hA5);
    check("t2_model_q", 32'(m_q_m), 32'hA5);
    d2 = sp_cyc - f2;

    // 3: same word with a 3-cycle stall after bit 4
    sp0 = sp_cnt;
    send_word(8'hA5, 4, 3, f3, l3);
    idle(3);
    check("t3_sp_count", 32'(sp_cnt - sp0), 32'd1);
    check("t3_sp_delay", 32'(sp_cyc - f3), 32'(d2 + 3));
    check("t3_q", 32'(bus_m.Q), 32'hA5);

    // 4: abort after 5 bits (DV also high on that edge), then 3C
    sp0 = sp_cnt;
    drive_bit(1'b1, a); drive_bit(1'b1, a); drive_bit(1'b0, a);
    drive_bit(1'b0, a); drive_bit(1'b1, a);
    @(negedge CK); #1;
    tb_abort = 1'b1; tb_dv = 1'b1; tb_di = 1'b1;
    send_word(8'h3C, -1, 0, f, l);
    idle(3);
    check("t4_sp_count", 32'(sp_cnt - sp0), 32'd1);
    check("t4_sp_after_last", 32'(sp_cyc), 32'(l));
    check("t4_q", 32'(bus_m.Q), 32'h3C);
    check("t4_model_q", 32'(m_q_m), 32'h3C);

    // 5: wire stream 1,0,0,0,0,0,0,0 -> LSB-first stage holds 01
    send_word(8'h80, -1, 0, f, l);
    idle(2);
    check("t5_q_lsb", 32'(bus_l.Q), 32'h01);
    check("t5_q_msb", 32'(bus_m.Q), 32'h80);
    check("t5_model_q_lsb", 32'(m_q_l), 32'h01);
    // two back-to-back words
    send_word(8'hC3, -1, 0, f, l);
    send_word(8'h5A, -1, 0, f, l);
    idle(3);
    if (sp_log.size() >= 2)
      check("t5_b2b_period", 32'(sp_log[$] - sp_log[$-1]), 32'(PERIOD));
    else
      check("t5_b2b_pulses", 32'(sp_log.size()), 32'd2);
    check("t5_q_lsb2", 32'(bus_l.Q), 32'h5A);

`ifdef PARITY_CHK_EN
    // 6: A5 with a good parity bit, then 01 with a bad one
    sp0 = sp_cnt;
    send_word(8'hA5, -1, 0, f, l);
    idle(2);
    check("t6_sp", 32'(sp_cnt - sp0), 32'd1);
    check("t6_q", 32'(bus_m.Q), 32'hA5);
    sp0 = sp_cnt;
    for (int k = 0; k < W; k++) drive_bit((k == W-1) ? 1'b1 : 1'b0, a);
    drive_bit(1'b0, a);
    idle(2);
    check("t6_perr_pulses", 32'(perr_cnt), 32'd1);
    check("t6_no_sp", 32'(sp_cnt - sp0), 32'd0);
    check("t6_q_kept", 32'(bus_m.Q), 32'hA5);
`endif

    // randomized phase
    for (int i = 0; i < 2000; i++) begin
      @(negedge CK); #1;
      CD       = ($urandom_range(0, 99) < 2);
      tb_dv    = ($urandom_range(0, 99) < 70);
      tb_di    = 1'($urandom_range(0, 1));
      tb_abort = ($urandom_range(0, 99) < 4);
    end
    @(negedge CK); #1;
    CD = 1'b0; tb_dv = 1'b0; tb_abort = 1'b0;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
